srt_div_sched: RTL and testbench
================================

Name: srt_div_sched

Overview:
- Shares one 8-bit radix-4 SRT divider (N/D in, Q/R out, active-low sync reset, start pulse, done level) among NREQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the divider: clear, launch, wait for done, capture result.
- Returns a tagged response over a valid/ready handshake. Divide-by-zero and divider hang are trapped without disturbing other requesters.

Parameters:
- NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ).
- TIMEOUT, 16, max cycles in WAIT before the divider is declared hung (>=8).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until granted.
- req_n  in  8*NREQ  dividends, requester i at [8i+7:8i].
- req_d  in  8*NREQ  divisors, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse; operands sampled that cycle.
- div_resetn  out  1  divider reset, active low.
- div_start  out  1  divider start.
- div_n  out  8  latched dividend.
- div_d  out  8  latched divisor.
- div_done  in  1  divider result valid.
- div_q  in  8  divider quotient.
- div_r  in  8  divider remainder.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  IDW  requester index of response.
- resp_q  out  8  quotient.
- resp_r  out  8  remainder.
- resp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset=1 at posedge):
  - state=IDLE, rr_ptr=0, wait count=0.
  - gnt=0, div_start=0, div_resetn=0, div_n=div_d=0.
  - resp_valid=0, resp_id=0, resp_q=resp_r=0, resp_err=0, busy=0.
  - Reset mid-operation abandons the op: no response, no retained grant.
- States: IDLE, CLR, LAUNCH, WAIT, RESP. All outputs are registered.
- IDLE:
  - div_resetn=1.
  - If req!=0, pick the first set bit at or after rr_ptr, wrapping modulo NREQ.
  - Assert gnt[w] for that cycle. Latch div_n/div_d and resp_id=w. Set rr_ptr=(w+1) mod NREQ.
  - If the latched D==0: resp_q=8'hFF, resp_r=N, resp_err=01, go to RESP (divider untouched).
  - Otherwise go to CLR.
- CLR: div_resetn=0 for exactly one cycle, flushing the divider STOP state; then LAUNCH.
- LAUNCH: div_resetn=1, div_start=1 for one cycle, count=0; then WAIT.
- WAIT:
  - div_start=0; count increments each cycle.
  - div_done=1: capture resp_q=div_q, resp_r=div_r, resp_err=00; go to RESP.
  - Else if count==TIMEOUT-1: resp_q=resp_r=0, resp_err=10, div_resetn=0 for one cycle; go to RESP.
  - div_done takes priority over timeout in the same cycle.
- RESP:
  - resp_valid=1. resp_id/q/r/err are stable while valid && !ready.
  - On resp_valid&&resp_ready: resp_valid=0 next cycle, go to IDLE.
  - No arbitration while in RESP; requests wait.
- Latency (no backpressure): grant cycle G, CLR at G+1, LAUNCH at G+2, WAIT from G+3.
  - resp_valid rises the cycle after div_done is seen.
  - Divide-by-zero: resp_valid at G+1.
- Minimum gap between consecutive grants: 1 IDLE cycle after the handshake.
- Fairness: with all req high, grants cycle 0,1,..,NREQ-1,0. A requester that drops req before grant is skipped without penalty.
- div_n/div_d hold from grant until the next grant.
- Operands are passed unmodified; divisor normalization is the requester's responsibility.
- gnt is never asserted outside IDLE; at most one bit is set.

Test Plan:
1. Reset, then req=0001 with N=8'h64, D=8'h90; divider model done after 5 cycles with Q=8'h00, R=8'h64 → gnt=0001 at G; div_resetn low at G+1; div_start at G+2; resp_valid with id=0, q=00, r=64, err=00; busy drops after handshake.
2. req=1111 held, resp_ready=1 → grant order 0,1,2,3,0; gnt is never multi-hot; each resp_id matches its grant.
3. req=0100, D=0, N=8'h37 → resp_valid at G+1 with id=2, q=FF, r=37, err=01; div_start is never asserted.
4. Divider model never asserts div_done → after TIMEOUT WAIT cycles, resp_err=10, q=r=0, one-cycle div_resetn low; the next request completes normally.
5. resp_ready=0 for 10 cycles during RESP with req=0011 pending → response fields stable, no gnt; after ready, the next grant goes to the requester after the last winner.
6. Assert reset while in WAIT → all outputs return to reset values next cycle; no resp_valid; rr_ptr=0, so requester 0 wins first after reset.

Source files
------------

// File: rtl/srt_div_sched.sv
`default_nettype none
// ============================================================================
//  Module   : srt_div_sched
//  Purpose  : Round-robin scheduler sharing one 8-bit SRT divider among
//             NREQ requesters; traps divide-by-zero and divider hang, and
//             returns a tagged result over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module srt_div_sched #(
  parameter int  NREQ    = 4,
  parameter int  TIMEOUT = 16,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_n,
  input  logic [8*NREQ-1:0] req_d,
  output logic [NREQ-1:0]   gnt,
  output logic              div_resetn,
  output logic              div_start,
  output logic [7:0]        div_n,
  output logic [7:0]        div_d,
  input  logic              div_done,
  input  logic [7:0]        div_q,
  input  logic [7:0]        div_r,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [7:0]        resp_q,
  output logic [7:0]        resp_r,
  output logic [1:0]        resp_err,
  output logic              busy
);

  localparam int CW = $clog2(TIMEOUT);

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_CLR    = 3'd1;
  localparam logic [2:0] c_S_LAUNCH = 3'd2;
  localparam logic [2:0] c_S_WAIT   = 3'd3;
  localparam logic [2:0] c_S_RESP   = 3'd4;

  localparam logic [1:0] c_ERR_OK  = 2'b00;
  localparam logic [1:0] c_ERR_DZ  = 2'b01;
  localparam logic [1:0] c_ERR_TMO = 2'b10;

  localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW:0]  c_NREQ     = (IDW + 1)'(NREQ);

  logic [2:0]      r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic            r_div_resetn;
  logic            r_div_start;
  logic [7:0]      r_div_n;
  logic [7:0]      r_div_d;
  logic            r_resp_valid;
  logic [IDW-1:0]  r_resp_id;
  logic [7:0]      r_resp_q;
  logic [7:0]      r_resp_r;
  logic [1:0]      r_resp_err;
  logic            r_busy;

  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [IDW:0]    w_sum;
  logic [IDW:0]    w_ptr_inc;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [NREQ-1:0] w_gnt_oh;
  logic [7:0]      w_op_n;
  logic [7:0]      w_op_d;

  // Round-robin search: first requesting index at or after r_rr_ptr, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW + 1)'(k);
      if (w_sum >= c_NREQ) begin
        w_sum = w_sum - c_NREQ;
      end
      if (!w_any && req[w_sum[IDW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_sum[IDW-1:0];
      end
    end
  end

  assign w_ptr_inc = {1'b0, w_win} + (IDW + 1)'(1);
  assign w_ptr_nxt = (w_ptr_inc >= c_NREQ) ? '0 : w_ptr_inc[IDW-1:0];
  assign w_gnt_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_win;

  // Select the winner's operand pair out of the packed request buses.
  always_comb begin
    w_op_n = 8'h00;
    w_op_d = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win == IDW'(k)) begin
        w_op_n = req_n[8*k +: 8];
        w_op_d = req_d[8*k +: 8];
      end
    end
  end

  // Scheduler FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_S_IDLE;
      r_rr_ptr     <= '0;
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_div_resetn <= 1'b0;
      r_div_start  <= 1'b0;
      r_div_n      <= 8'h00;
      r_div_d      <= 8'h00;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_q     <= 8'h00;
      r_resp_r     <= 8'h00;
      r_resp_err   <= c_ERR_OK;
      r_busy       <= 1'b0;
    end else begin
      // gnt and div_start are single-cycle pulses
      r_gnt       <= '0;
      r_div_start <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          r_div_resetn <= 1'b1;
          if (r_gnt != '0) begin
            // Grant cycle: operands already latched, decide the path.
            r_busy <= 1'b1;
            if (r_div_d == 8'h00) begin
              r_resp_q     <= 8'hFF;
              r_resp_r     <= r_div_n;
              r_resp_err   <= c_ERR_DZ;
              r_resp_valid <= 1'b1;
              r_state      <= c_S_RESP;
            end else begin
              r_div_resetn <= 1'b0;
              r_state      <= c_S_CLR;
            end
          end else if (w_any) begin
            r_gnt     <= w_gnt_oh;
            r_div_n   <= w_op_n;
            r_div_d   <= w_op_d;
            r_resp_id <= w_win;
            r_rr_ptr  <= w_ptr_nxt;
          end
        end
        c_S_CLR: begin
          r_div_resetn <= 1'b1;
          r_div_start  <= 1'b1;
          r_cnt        <= '0;
          r_state      <= c_S_LAUNCH;
        end
        c_S_LAUNCH: begin
          r_state <= c_S_WAIT;
        end
        c_S_WAIT: begin
          if (div_done) begin
            // A result arriving on the last allowed cycle still wins.
            r_resp_q     <= div_q;
            r_resp_r     <= div_r;
            r_resp_err   <= c_ERR_OK;
            r_resp_valid <= 1'b1;
            r_state      <= c_S_RESP;
          end else if (r_cnt == c_CNT_LAST) begin
            // Divider hung: report and pulse its reset so it is reusable.
            r_resp_q     <= 8'h00;
            r_resp_r     <= 8'h00;
            r_resp_err   <= c_ERR_TMO;
            r_div_resetn <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= c_S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        c_S_RESP: begin
          r_div_resetn <= 1'b1;
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= c_S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= c_S_IDLE;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign div_resetn = r_div_resetn;
  assign div_start  = r_div_start;
  assign div_n      = r_div_n;
  assign div_d      = r_div_d;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_q     = r_resp_q;
  assign resp_r     = r_resp_r;
  assign resp_err   = r_resp_err;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_srt_div_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_srt_div_sched
//  Purpose  : Self-checking bench for srt_div_sched with a behavioural
//             divider and a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_srt_div_sched;

  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_n;
  logic [31:0] req_d;
  logic [3:0]  gnt;
  logic        div_resetn;
  logic        div_start;
  logic [7:0]  div_n;
  logic [7:0]  div_d;
  logic        div_done = 1'b0;
  logic [7:0]  div_q = 8'h00;
  logic [7:0]  div_r = 8'h00;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [7:0]  resp_q;
  logic [7:0]  resp_r;
  logic [1:0]  resp_err;
  logic        busy;

  logic [7:0]  op_n [4];
  logic [7:0]  op_d [4];

  int          total;
  int          bad;
  int          m_ptr;
  int          m_lat;
  bit          m_hang;

  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [7:0]  m_n = 8'h00;
  logic [7:0]  m_d = 8'h01;

  assign req_n = {op_n[3], op_n[2], op_n[1], op_n[0]};
  assign req_d = {op_d[3], op_d[2], op_d[1], op_d[0]};

  srt_div_sched #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_n      (req_n),
    .req_d      (req_d),
    .gnt        (gnt),
    .div_resetn (div_resetn),
    .div_start  (div_start),
    .div_n      (div_n),
    .div_d      (div_d),
    .div_done   (div_done),
    .div_q      (div_q),
    .div_r      (div_r),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_q     (resp_q),
    .resp_r     (resp_r),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Divider stand-in: done (level) m_lat cycles after start, or never when hung.
  always @(posedge clk) begin
    if (!div_resetn) begin
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      div_done <= 1'b0;
      div_q    <= 8'h00;
      div_r    <= 8'h00;
    end else if (div_start) begin
      m_busy   <= 1'b1;
      m_cnt    <= 0;
      div_done <= 1'b0;
      m_n      <= div_n;
      m_d      <= div_d;
    end else if (m_busy && !m_hang) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == m_lat - 1) begin
        m_busy   <= 1'b0;
        div_done <= 1'b1;
        div_q    <= m_n / m_d;
        div_r    <= m_n % m_d;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester at or after ptr, wrapping.
  function automatic int pick(input logic [3:0] p, input int ptr);
    int r;
    r = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (r < 0 && p[(ptr + k) % NREQ]) r = (ptr + k) % NREQ;
    end
    return r;
  endfunction

  task automatic check_reset(input string pfx);
    chk({pfx, "_gnt"},   gnt,        0);
    chk({pfx, "_start"}, div_start,  0);
    chk({pfx, "_rstn"},  div_resetn, 0);
    chk({pfx, "_dn"},    div_n,      0);
    chk({pfx, "_dd"},    div_d,      0);
    chk({pfx, "_valid"}, resp_valid, 0);
    chk({pfx, "_id"},    resp_id,    0);
    chk({pfx, "_q"},     resp_q,     0);
    chk({pfx, "_r"},     resp_r,     0);
    chk({pfx, "_err"},   resp_err,   0);
    chk({pfx, "_busy"},  busy,       0);
  endtask

  // One full transaction from an idle scheduler with req already driven.
  task automatic serve(input logic [3:0] after_req, input int stall,
                       input logic [3:0] pend, output int got);
    int w, cyc, k, ns, nr, elat;
    logic [7:0] en, ed, eq, er;
    logic [1:0] ee;
    logic r1, s2;
    w   = pick(req, m_ptr);
    cyc = 0;
    while (gnt == 4'b0 && cyc < 40) begin
      tick();
      cyc++;
    end
    got = -1;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) got = i;
    chk("gnt_wait", cyc, 1);
    chk("gnt_vec", gnt, 1 << w);
    chk("busy_at_gnt", busy, 0);
    en = op_n[w];
    ed = op_d[w];
    chk("div_n", div_n, en);
    chk("div_d", div_d, ed);
    m_ptr = (w + 1) % NREQ;
    req   = after_req;
    if (ed == 8'h00) begin
      eq = 8'hFF; er = en; ee = 2'b01; elat = 1;
    end else if (m_hang || m_lat >= TMO) begin
      eq = 8'h00; er = 8'h00; ee = 2'b10; elat = TMO + 3;
    end else begin
      eq = en / ed; er = en % ed; ee = 2'b00; elat = m_lat + 4;
    end
    k = 0; ns = 0; nr = 0; r1 = 1'b0; s2 = 1'b0;
    while (!resp_valid && k < 60) begin
      tick();
      k++;
      chk("gnt_quiet", gnt, 0);
      if (!resp_valid) begin
        if (div_start) ns++;
        if (!div_resetn) nr++;
        if (k == 1) r1 = !div_resetn;
        if (k == 2) s2 = div_start;
      end
    end
    chk("resp_lat", k, elat);
    chk("start_cnt", ns, (ed == 8'h00) ? 0 : 1);
    chk("clr_cnt", nr, (ed == 8'h00) ? 0 : 1);
    if (ed != 8'h00) begin
      chk("clr_pos", r1, 1);
      chk("start_pos", s2, 1);
    end
    chk("rstn_at_resp", div_resetn, (ee == 2'b10) ? 0 : 1);
    if (stall > 0) req = pend;
    for (int s = 0; s <= stall; s++) begin
      chk("valid", resp_valid, 1);
      chk("id", resp_id, w);
      chk("q", resp_q, eq);
      chk("r", resp_r, er);
      chk("err", resp_err, ee);
      chk("busy_resp", busy, 1);
      chk("gnt_resp", gnt, 0);
      if (s == 1) chk("rstn_after", div_resetn, 1);
      if (s == stall) resp_ready = 1'b1;
      tick();
    end
    resp_ready = 1'b0;
    chk("valid_drop", resp_valid, 0);
    chk("busy_drop", busy, 0);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_n[i] = 8'($urandom_range(0, 255));
      op_d[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    end
  endtask

  initial begin
    int got, cyc;
    total = 0; bad = 0;
    reset = 1'b1; req = 4'b0; resp_ready = 1'b0;
    m_lat = 5; m_hang = 1'b0; m_ptr = 0;
    for (int i = 0; i < NREQ; i++) begin
      op_n[i] = 8'h00;
      op_d[i] = 8'h01;
    end
    tick();
    check_reset("rst0");
    reset = 1'b0;
    tick();

    // Single requester, normal divide with 5-cycle divider.
    op_n[0] = 8'h64; op_d[0] = 8'h90; m_lat = 5; req = 4'b0001;
    serve(4'b0000, 0, 4'b0000, got);

    // Fresh pointer, all requesting and holding: 0,1,2,3,0.
    reset = 1'b1; tick(); check_reset("rst1"); reset = 1'b0; m_ptr = 0; tick();
    for (int i = 0; i < NREQ; i++) begin
      op_n[i] = 8'($urandom_range(0, 255));
      op_d[i] = 8'($urandom_range(1, 255));
    end
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      m_lat = $urandom_range(1, 14);
      serve((i == 4) ? 4'b0000 : 4'b1111, 0, 4'b0000, got);
      chk("rr_order", got, i % NREQ);
    end

    // Divide-by-zero from requester 2.
    op_n[2] = 8'h37; op_d[2] = 8'h00; req = 4'b0100;
    serve(4'b0000, 0, 4'b0000, got);

    // Hung divider, then normal op, then done on the very last WAIT cycle,
    // then done one cycle too late.
    op_n[1] = 8'hC8; op_d[1] = 8'h07; m_hang = 1'b1; req = 4'b0010;
    serve(4'b0000, 2, 4'b0000, got);
    m_hang = 1'b0; m_lat = 3; op_n[1] = 8'hF1; op_d[1] = 8'h0D; req = 4'b0010;
    serve(4'b0000, 0, 4'b0000, got);
    m_lat = TMO - 1; op_n[3] = 8'h9A; op_d[3] = 8'h05; req = 4'b1000;
    serve(4'b0000, 0, 4'b0000, got);
    m_lat = TMO; req = 4'b1000;
    serve(4'b0000, 0, 4'b0000, got);

    // Backpressure with 0011 pending; next winner is the one after 0.
    m_lat = 4;
    op_n[0] = 8'h80; op_d[0] = 8'h03; op_n[1] = 8'h51; op_d[1] = 8'h11;
    req = 4'b0001;
    serve(4'b0000, 10, 4'b0011, got);
    serve(4'b0000, 0, 4'b0000, got);
    chk("after_stall_winner", got, 1);

    // Reset while waiting on a hung divider.
    op_n[3] = 8'hA5; op_d[3] = 8'h09; m_hang = 1'b1; req = 4'b1000;
    cyc = 0;
    while (gnt == 4'b0 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t6_gnt", gnt, 4'b1000);
    req = 4'b0000;
    repeat (5) tick();
    chk("t6_busy", busy, 1);
    reset = 1'b1;
    tick();
    check_reset("rst2");
    reset = 1'b0; m_ptr = 0; m_hang = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_novalid", resp_valid, 0);
    end
    rand_ops();
    op_d[0] = 8'h07; m_lat = 4; req = 4'b1111;
    serve(4'b0000, 0, 4'b0000, got);
    chk("t6_first_winner", got, 0);

    // Randomised traffic.
    for (int t = 0; t < 24; t++) begin
      rand_ops();
      m_lat  = $urandom_range(1, TMO);
      m_hang = ($urandom_range(0, 9) == 0);
      req    = 4'($urandom_range(1, 15));
      serve(4'b0000, $urandom_range(0, 3), 4'b0000, got);
    end
    m_hang = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
